// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - multi-channel PWM with per-period duty ramping toward commanded targets
module pwm_ramp_ctrl #(
  parameter int NCH    = 4,
  parameter int PERIOD = 100,
  parameter int DW     = 8,
  parameter int CHW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_ch,
  input  logic [DW-1:0]     cmd_target,
  input  logic [DW-1:0]     cmd_step,
  input  logic              cmd_imm,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH*DW-1:0] duty_o,
  output logic [NCH-1:0]    busy,
  output logic              period_end
);

  localparam logic [DW-1:0] LAST = DW'(PERIOD - 1);
  localparam logic [DW-1:0] PMAX = DW'(PERIOD);

  logic [DW-1:0]  cnt;
  logic [DW-1:0]  duty     [NCH];
  logic [DW-1:0]  target   [NCH];
  logic [DW-1:0]  step_val [NCH];
  logic [DW-1:0]  nxt      [NCH];
  logic [NCH-1:0] imm;
  logic [NCH-1:0] sel;
  logic           boundary;
  logic           accept;
  logic [DW-1:0]  tgt_cl;
  logic [DW-1:0]  step_nz;

  assign boundary  = (cnt == LAST);
  assign cmd_ready = !rst && !boundary;
  assign accept    = cmd_valid && cmd_ready;
  assign tgt_cl    = (cmd_target > PMAX) ? PMAX : cmd_target;
  assign step_nz   = (cmd_step == '0) ? DW'(1) : cmd_step;

  // Out-of-range channel indices match no select bit, so such commands are dropped.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++)
      sel[i] = accept && (cmd_ch == CHW'(i));
  end

  // Gaps and sums are formed one bit wider so neither direction can wrap.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nxt[i] = duty[i];
      if (imm[i])
        nxt[i] = target[i];
      else if (duty[i] < target[i])
        nxt[i] = (({1'b0, target[i]} - {1'b0, duty[i]}) <= {1'b0, step_val[i]}) ?
                 target[i] : DW'({1'b0, duty[i]} + {1'b0, step_val[i]});
      else if (duty[i] > target[i])
        nxt[i] = (({1'b0, duty[i]} - {1'b0, target[i]}) <= {1'b0, step_val[i]}) ?
                 target[i] : DW'({1'b0, duty[i]} - {1'b0, step_val[i]});
    end
  end

  always_comb begin
    duty_o = '0;
    for (int i = 0; i < NCH; i++)
      duty_o[i*DW +: DW] = duty[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      period_end <= 1'b0;
      pwm_out    <= '0;
      busy       <= '0;
      imm        <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty[i]     <= '0;
        target[i]   <= '0;
        step_val[i] <= DW'(1);
      end
    end else begin
      cnt        <= boundary ? '0 : cnt + DW'(1);
      period_end <= boundary;
      for (int i = 0; i < NCH; i++) begin
        pwm_out[i] <= (cnt < duty[i]);
        busy[i]    <= (duty[i] != target[i]);
        if (boundary)
          duty[i] <= nxt[i];
        if (sel[i]) begin
          target[i]   <= tgt_cl;
          step_val[i] <= step_nz;
          imm[i]      <= cmd_imm;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  localparam int NCH = 4;
  localparam int P   = 100;
  localparam int DW  = 8;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CHW-1:0]    cmd_ch = '0;
  logic [DW-1:0]     cmd_target = '0;
  logic [DW-1:0]     cmd_step = '0;
  logic              cmd_imm = 1'b0;
  logic [NCH-1:0]    pwm_out;
  logic [NCH*DW-1:0] duty_o;
  logic [NCH-1:0]    busy;
  logic              period_end;

  pwm_ramp_ctrl #(.NCH(NCH), .PERIOD(P), .DW(DW), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_imm(cmd_imm),
    .pwm_out(pwm_out), .duty_o(duty_o), .busy(busy), .period_end(period_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*DW-1:0] dnew;
    logic [NCH*DW-1:0] dold;
    logic [NCH-1:0]    bnew;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   m_cnt;
  int   m_duty [NCH];
  int   m_tgt  [NCH];
  int   m_step [NCH];
  bit   m_imm  [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dch(input int ch);
    return duty_o[ch*DW +: DW];
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = 0; m_tgt[i] = 0; m_step[i] = 1; m_imm[i] = 0;
    end
    q.delete();
  endtask

  // One clock: model follows the DUT at the edge; boundary pushes the next period's expectations.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (cmd_valid && m_cnt != P-1 && int'(cmd_ch) < NCH) begin
        m_tgt[cmd_ch]  = (int'(cmd_target) > P) ? P : int'(cmd_target);
        m_step[cmd_ch] = (cmd_step == 0) ? 1 : int'(cmd_step);
        m_imm[cmd_ch]  = cmd_imm;
      end
      if (m_cnt == P-1) begin
        for (int i = 0; i < NCH; i++) begin
          e.dold[i*DW +: DW] = DW'(m_duty[i]);
          if (m_imm[i]) m_duty[i] = m_tgt[i];
          else if (m_duty[i] < m_tgt[i])
            m_duty[i] = (m_tgt[i] - m_duty[i] <= m_step[i]) ? m_tgt[i] : m_duty[i] + m_step[i];
          else if (m_duty[i] > m_tgt[i])
            m_duty[i] = (m_duty[i] - m_tgt[i] <= m_step[i]) ? m_tgt[i] : m_duty[i] - m_step[i];
          e.dnew[i*DW +: DW] = DW'(m_duty[i]);
          e.bnew[i] = (m_duty[i] != m_tgt[i]);
        end
        q.push_back(e);
      end
      m_cnt = (m_cnt == P-1) ? 0 : m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 2*P && m_cnt != c; k++) step();
  endtask

  task automatic next_period();
    step();
    run_to(0);
  endtask

  task automatic send(input int ch, input int tgt, input int stp, input bit im);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_ch = CHW'(ch); cmd_target = DW'(tgt); cmd_step = DW'(stp); cmd_imm = im;
    for (int k = 0; k < 4 && !acc; k++) begin
      acc = (m_cnt != P-1);
      chk("cmd_ready", cmd_ready, acc);
      step();
    end
    cmd_valid = 1'b0;
  endtask

  // Monitor: counts pwm high cycles per period, pops expectations on each period_end pulse.
  initial begin
    int hi [NCH];
    logic [NCH-1:0] pend_busy;
    bit pend;
    exp_t e;
    pend = 0;
    pend_busy = '0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        pend = 0;
      end else begin
        if (pend) begin
          chk("busy", busy, pend_busy);
          pend = 0;
        end
        for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
        if (period_end) begin
          if (q.size() == 0) chk("period_end_unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk("duty_o", duty_o, e.dnew);
            for (int i = 0; i < NCH; i++)
              chk($sformatf("pwm_hi%0d", i), hi[i], e.dold[i*DW +: DW]);
            pend_busy = e.bnew;
            pend = 1;
          end
          for (int i = 0; i < NCH; i++) hi[i] = 0;
        end
      end
    end
  end

  initial begin
    int ramp1 [3];
    int ramp2 [3];
    ramp1 = '{7, 14, 20};
    ramp2 = '{60, 20, 0};
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_duty", duty_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", period_end, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rel_ready", cmd_ready, 1);

    run_to(10);
    send(0, 30, 1, 1);
    run_to(50);
    chk("imm_hold", dch(0), 0);
    next_period();
    chk("imm_set", dch(0), 30);

    send(1, 20, 7, 0);
    for (int k = 0; k < 3; k++) begin
      next_period();
      chk("ramp_up", dch(1), ramp1[k]);
    end
    run_to(2);
    chk("ramp_busy", busy[1], 0);
    next_period();
    chk("ramp_hold", dch(1), 20);

    send(2, 100, 5, 1);
    next_period();
    chk("full", dch(2), 100);
    send(2, 250, 0, 0);
    next_period();
    chk("clamp_hold", dch(2), 100);
    run_to(2);
    chk("clamp_busy", busy[2], 0);
    send(2, 0, 40, 0);
    for (int k = 0; k < 3; k++) begin
      next_period();
      chk("ramp_dn", dch(2), ramp2[k]);
    end
    next_period();
    run_to(50);
    chk("zero_low", pwm_out[2], 0);

    run_to(P-1);
    send(3, 50, 1, 1);
    send(3, 10, 1, 1);
    next_period();
    chk("overwrite", dch(3), 10);

    send(1, 0, 1, 1);
    next_period();
    chk("ch1_zero", dch(1), 0);
    send(1, 90, 10, 0);
    repeat (4) next_period();
    chk("mid_duty", dch(1), 40);
    run_to(5);
    rst = 1'b1;
    step();
    chk("mrst_duty", duty_o, 0);
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_pend", period_end, 0);
    chk("mrst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("mrst_rel_ready", cmd_ready, 1);
    next_period();
    next_period();
    chk("no_resume", duty_o, 0);
    run_to(3);
    chk("no_resume_busy", busy, 0);

    chk("q_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
